// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared types and constants for the MIPS fetch stage.
//               Holds the fetch FSM state encoding, the default reset PC,
//               the instruction field positions and a branch-offset helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Instruction field positions
    localparam int c_OPCODE_MSB   = 31;
    localparam int c_OPCODE_LSB   = 26;
    localparam int c_IMM16_MSB    = 15;
    localparam int c_IMM16_LSB    = 0;
    localparam int c_TARGET26_MSB = 25;
    localparam int c_TARGET26_LSB = 0;

    // Sign-extended immediate converted from a word offset to a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Instruction-memory read bus between the fetch stage and
//               instruction memory (req/ready handshake).
// Ports       : imem_req   - read request (fetch -> memory)
//               imem_addr  - word-aligned read address (fetch -> memory)
//               imem_ready - read data valid this cycle (memory -> fetch)
//               imem_rdata - instruction word (memory -> fetch)
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    import mips_pkg::*;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/fetch_unit_pc_next.sv
`default_nettype none
// ============================================================================
// Module      : pc_next
// Description : Combinational next-PC selection for the fetch stage.
//               Jump beats a taken branch; otherwise sequential PC+4.
// Ports       : pc_plus4  - current PC + 4
//               instr     - held instruction (imm16 / target26 source)
//               branch    - beq-style branch (taken on zero)
//               branch_ne - bne-style branch (taken on not zero)
//               jump      - unconditional jump
//               zero      - ALU zero flag
//               next_pc   - selected next PC, bits [1:0] forced to 0
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next
    import mips_pkg::*;
(
    input  wire logic [31:0] pc_plus4,
    input  wire logic [31:0] instr,
    input  wire logic        branch,
    input  wire logic        branch_ne,
    input  wire logic        jump,
    input  wire logic        zero,
    output logic      [31:0] next_pc
);

    logic        w_taken;
    logic [31:0] w_target;

    // Opcode bits are not needed to form the address.
    wire w_unused = &{1'b0, instr[c_OPCODE_MSB:c_OPCODE_LSB]};

    assign w_taken = (branch & zero) | (branch_ne & ~zero);

    always_comb begin
        w_target = pc_plus4;
        if (jump) begin
            w_target = {pc_plus4[31:28], instr[c_TARGET26_MSB:c_TARGET26_LSB], 2'b00};
        end else if (w_taken) begin
            w_target = pc_plus4 + branch_offset(instr[c_IMM16_MSB:c_IMM16_LSB]);
        end
    end

    assign next_pc = {w_target[31:2], 2'b00};

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Owns the PC, reads instruction
//               memory over a req/ready handshake, holds the fetched word
//               for decode, and advances the PC on instr_accept using the
//               control unit's branch/jump decisions.
// Ports       : clk, reset          - clock, async active-high reset
//               imem (master)       - instruction memory read bus
//               instr, instr_valid  - held instruction and its valid flag
//               instr_accept        - core commits the held instruction
//               branch, branch_ne,
//               jump, zero          - next-PC controls (sampled on accept)
//               pc, pc_plus4        - current PC and PC+4
//               fetch_count         - committed-instruction counter
// Config      : FETCH_PERF_CNT_EN   - build the fetch_count register;
//                                     otherwise fetch_count is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  wire logic        clk,
    input  wire logic        reset,
    fetch_unit_if.master     imem,
    output logic      [31:0] instr,
    output logic             instr_valid,
    input  wire logic        instr_accept,
    input  wire logic        branch,
    input  wire logic        branch_ne,
    input  wire logic        jump,
    input  wire logic        zero,
    output logic      [31:0] pc,
    output logic      [31:0] pc_plus4,
    output logic      [31:0] fetch_count
);

    localparam logic [31:0] c_RESET_PC_ALIGNED = RESET_PC & ~32'h3;

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  instr_q;
    logic         valid_q;
    logic         req_q;
    logic         w_commit;

    assign pc_plus4 = pc_q + 32'd4;
    assign w_commit = valid_q & instr_accept;

    pc_next u_pc_next (
        .pc_plus4  (pc_plus4),
        .instr     (instr_q),
        .branch    (branch),
        .branch_ne (branch_ne),
        .jump      (jump),
        .zero      (zero),
        .next_pc   (pc_d)
    );

    // req_q is cleared by reset and raised on the first clock afterwards,
    // so a memory response left over from before reset is never taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= c_RESET_PC_ALIGNED;
            instr_q <= '0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (imem.imem_ready) begin
                        instr_q <= imem.imem_rdata;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (instr_accept) begin
                        pc_q    <= pc_d;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= ST_FETCH;
                    end
                end
                default: begin
                    state_q <= ST_FETCH;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (w_commit) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign fetch_count = count_q;
`else
    wire w_unused_commit = w_commit;
    assign fetch_count = '0;
`endif

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = valid_q;
    assign pc             = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit. Walks the PC
//               through sequential, branch, jump and wrap cases, then checks
//               reset in the middle of a pending request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        instr_accept;
    logic        branch;
    logic        branch_ne;
    logic        jump;
    logic        zero;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] fetch_count;

    int n_tests;
    int n_fail;
    int n_acc;

    fetch_unit_if imem_bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem         (imem_bus.master),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_accept (instr_accept),
        .branch       (branch),
        .branch_ne    (branch_ne),
        .jump         (jump),
        .zero         (zero),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .fetch_count  (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_count();
`ifdef FETCH_PERF_CNT_EN
        return 32'(n_acc);
`else
        return 32'h0;
`endif
    endfunction

    // Called at a negedge with the request already up at addr.
    task automatic fetch_word(input logic [31:0] addr, input logic [31:0] word, input int waits);
        chk("req_up",    {31'b0, imem_bus.imem_req}, 32'h1);
        chk("addr",      imem_bus.imem_addr, addr);
        chk("pc_plus4",  pc_plus4, addr + 32'd4);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            chk("req_wait",   {31'b0, imem_bus.imem_req}, 32'h1);
            chk("addr_wait",  imem_bus.imem_addr, addr);
            chk("valid_wait", {31'b0, instr_valid}, 32'h0);
        end
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = word;
        @(negedge clk);
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        chk("valid_up", {31'b0, instr_valid}, 32'h1);
        chk("instr",    instr, word);
        chk("req_down", {31'b0, imem_bus.imem_req}, 32'h0);
    endtask

    task automatic accept(input logic b, input logic bne, input logic j, input logic z,
                          input logic [31:0] exp_pc);
        instr_accept = 1'b1;
        branch       = b;
        branch_ne    = bne;
        jump         = j;
        zero         = z;
        @(negedge clk);
        instr_accept = 1'b0;
        branch       = 1'b0;
        branch_ne    = 1'b0;
        jump         = 1'b0;
        zero         = 1'b0;
        n_acc++;
        chk("next_pc",    pc, exp_pc);
        chk("next_addr",  imem_bus.imem_addr, exp_pc);
        chk("next_req",   {31'b0, imem_bus.imem_req}, 32'h1);
        chk("next_valid", {31'b0, instr_valid}, 32'h0);
        chk("count",      fetch_count, exp_count());
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        n_acc   = 0;
        reset        = 1'b1;
        instr_accept = 1'b0;
        branch       = 1'b0;
        branch_ne    = 1'b0;
        jump         = 1'b0;
        zero         = 1'b0;
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = 32'h0;

        repeat (2) @(negedge clk);
        chk("rst_req",   {31'b0, imem_bus.imem_req}, 32'h0);
        chk("rst_addr",  imem_bus.imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_pc",    pc, 32'h0);
        chk("rst_pc4",   pc_plus4, 32'h4);
        chk("rst_count", fetch_count, 32'h0);

        reset = 1'b0;
        @(negedge clk);
        fetch_word(32'h0, 32'h2008_0005, 2);

        // Ready while no request is outstanding must not disturb instr.
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        chk("hold_instr", instr, 32'h2008_0005);
        chk("hold_valid", {31'b0, instr_valid}, 32'h1);
        chk("hold_pc",    pc, 32'h0);

        accept(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0004);

        // Accept while no instruction is valid is ignored.
        instr_accept = 1'b1;
        jump         = 1'b1;
        @(negedge clk);
        instr_accept = 1'b0;
        jump         = 1'b0;
        chk("ign_acc_pc",    pc, 32'h0000_0004);
        chk("ign_acc_count", fetch_count, exp_count());

        fetch_word(32'h0000_0004, 32'h0800_0004, 0);
        accept(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0010);

        fetch_word(32'h0000_0010, 32'h0000_0000, 1);
        accept(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0014);

        fetch_word(32'h0000_0014, 32'h1000_000A, 0);
        accept(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0040);

        fetch_word(32'h0000_0040, 32'h1000_FFFF, 0);
        accept(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0040);

        fetch_word(32'h0000_0040, 32'h1000_FFFF, 0);
        accept(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0044);

        fetch_word(32'h0000_0044, 32'h1400_FFFE, 0);
        accept(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040);

        fetch_word(32'h0000_0040, 32'h1400_0003, 0);
        accept(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0050);

        fetch_word(32'h0000_0050, 32'h1000_FFEA, 0);
        accept(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);

        fetch_word(32'hFFFF_FFFC, 32'h0000_0000, 0);
        accept(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);

        fetch_word(32'h0000_0000, 32'h0BFF_FFFF, 0);
        accept(1'b0, 1'b0, 1'b1, 1'b0, 32'h0FFF_FFFC);

        fetch_word(32'h0FFF_FFFC, 32'h0000_0000, 0);
        accept(1'b0, 1'b0, 1'b0, 1'b0, 32'h1000_0000);

        fetch_word(32'h1000_0000, 32'h0800_0100, 0);
        accept(1'b1, 1'b0, 1'b1, 1'b1, 32'h1000_0400);

        // Reset while the request to 0x1000_0400 is pending.
        @(negedge clk);
        chk("pend_req", {31'b0, imem_bus.imem_req}, 32'h1);
        reset = 1'b1;
        #1;
        chk("arst_req",   {31'b0, imem_bus.imem_req}, 32'h0);
        chk("arst_pc",    pc, 32'h0);
        chk("arst_addr",  imem_bus.imem_addr, 32'h0);
        chk("arst_pc4",   pc_plus4, 32'h4);
        chk("arst_count", fetch_count, 32'h0);
        @(negedge clk);
        imem_bus.imem_ready = 1'b1;
        imem_bus.imem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("arst_valid", {31'b0, instr_valid}, 32'h0);
        chk("arst_instr", instr, 32'h0);
        chk("arst_req2",  {31'b0, imem_bus.imem_req}, 32'h0);
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        reset = 1'b0;
        n_acc = 0;
        @(negedge clk);
        chk("post_valid", {31'b0, instr_valid}, 32'h0);
        fetch_word(32'h0000_0000, 32'h2008_0005, 0);
        accept(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
